// File: rtl/cpu_busif.sv
// Cache external-request port to single-beat 64-bit memory bus bridge.
// Write beats are queued in a small FIFO; one read (up to a 4-beat line)
// is held in a read context and replayed to the cache beat by beat in
// critical-word-first wrap order. Reads never overtake buffered writes.
module cpu_busif #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        phi2,
  input  logic [31:0] extaddr,
  input  logic [4:0]  extsz,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  input  logic [63:0] extwdata,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        werr
);

  localparam int AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(WBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_REPLY} state_t;
  state_t state, state_nxt;

  // write-beat FIFO
  logic [31:0]   fifo_addr [WBUF_DEPTH];
  logic [63:0]   fifo_data [WBUF_DEPTH];
  logic [7:0]    fifo_strb [WBUF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;
  logic          wfull, wempty, wpush, wpop;

  // write-burst tracking and the entry being pushed
  logic [1:0]  wbeat;
  logic [31:0] wbase;
  logic        wline_last;
  logic [2:0]  push_sh;
  logic [31:0] push_addr;
  logic [63:0] push_data;
  logic [7:0]  push_strb;

  // read context and reply register
  logic        rbusy, rline16, rline32, rsrc, rpush, rlast;
  logic [31:0] raddr;
  logic [1:0]  rbeat;
  logic [31:0] beat_addr;
  logic [63:0] rep_data;
  logic        rep_err;

  // Place right-justified sub-doubleword data on its big-endian byte lanes.
  function automatic logic [63:0] align_wdata(input logic [63:0] d, input logic [2:0] sh);
    return d << {sh, 3'b000};
  endfunction

  // Strobe (sz+1) contiguous lanes starting at lane sh.
  function automatic logic [7:0] lane_mask(input logic [2:0] sz, input logic [2:0] sh);
    logic [7:0] m;
    m = 8'hFF >> (3'd7 - sz);
    return m << sh;
  endfunction

  assign wfull  = (fcnt == FULL_CNT);
  assign wempty = (fcnt == '0);
  // Held low in reset so every output reads 0 while rstn is asserted.
  assign extrdy = rstn && (extwr ? !wfull : !rbusy);
  assign wpush  = phi2 && extreq && extwr && !wfull;
  assign rpush  = phi2 && extreq && !extwr && !rbusy;
  assign wpop   = (state == S_WRITE) && mem_ack;
  assign rlast  = rline32 ? (rbeat == 2'd3) : (rline16 ? (rbeat == 2'd1) : 1'b1);

  // Build the FIFO entry for the write beat presented by the cache.
  always_comb begin
    push_sh    = 3'd7 - extsz[2:0] - extaddr[2:0];
    push_addr  = {extaddr[31:3], 3'b000};
    push_data  = align_wdata(extwdata, push_sh);
    push_strb  = lane_mask(extsz[2:0], push_sh);
    wline_last = extsz[4] ? (wbeat == 2'd3) : (wbeat == 2'd1);
    if (extsz[3]) begin
      // later burst beats derive their address from the first; extaddr is ignored
      if (wbeat != 2'd0) push_addr = wbase + {27'd0, wbeat, 3'b000};
      push_data = extwdata;
      push_strb = 8'hFF;
    end
  end

  // Wrap the beat offset inside the 16- or 32-byte line.
  always_comb begin
    beat_addr = {raddr[31:3], 3'b000};
    if (rline32)      beat_addr[4:3] = raddr[4:3] + rbeat;
    else if (rline16) beat_addr[3]   = raddr[3] ^ rbeat[0];
  end

  // Datapath storage: FIFO entries, burst base, read context, reply capture.
  always_ff @(posedge clk) begin
    if (wpush) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_strb[wr_ptr] <= push_strb;
      if (extsz[3] && (wbeat == 2'd0)) wbase <= push_addr;
    end
    if (rpush) begin
      raddr   <= extaddr;
      rline16 <= extsz[3] & ~extsz[4];
      rline32 <= extsz[4];
      rsrc    <= extsrc;
    end
    if ((state == S_READ) && mem_ack) begin
      rep_data <= mem_rdata;
      rep_err  <= mem_err;
    end
  end

  // Control state: FSM, FIFO pointers/occupancy, burst and read beat counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      wbeat  <= '0;
      rbusy  <= 1'b0;
      rbeat  <= '0;
      werr   <= 1'b0;
    end else begin
      state <= state_nxt;
      werr  <= wpop && mem_err;
      if (wpush) wr_ptr <= wr_ptr + 1'b1;
      if (wpop)  rd_ptr <= rd_ptr + 1'b1;
      case ({wpush, wpop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      if (wpush && extsz[3]) wbeat <= wline_last ? 2'd0 : wbeat + 2'd1;
      if (rpush) begin
        rbusy <= 1'b1;
        rbeat <= '0;
      end else if ((state == S_REPLY) && phi2) begin
        if (rlast) begin
          rbusy <= 1'b0;
          rbeat <= '0;
        end else begin
          rbeat <= rbeat + 2'd1;
        end
      end
    end
  end

  // Next-state and bus/reply outputs; outputs are zero outside their state.
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    extreply   = 1'b0;
    extreplyto = 1'b0;
    extrdata   = '0;
    exterror   = 1'b0;
    case (state)
      S_IDLE: begin
        // a write being pushed this cycle also takes priority over the read
        if (!wempty)              state_nxt = S_WRITE;
        else if (rbusy && !wpush) state_nxt = S_READ;
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr];
        mem_wdata = fifo_data[rd_ptr];
        mem_wstrb = fifo_strb[rd_ptr];
        if (mem_ack) state_nxt = S_IDLE;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = beat_addr;
        if (mem_ack) state_nxt = S_REPLY;
      end
      S_REPLY: begin
        extreply   = 1'b1;
        extreplyto = rsrc;
        extrdata   = rep_data;
        exterror   = rep_err;
        if (phi2) state_nxt = rlast ? S_IDLE : S_READ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_busif.sv
// Directed bench for cpu_busif: memory responder and reply monitor pop
// expected beats/replies from scoreboard queues filled by the stimulus.
module tb_cpu_busif;
  logic        clk, rstn, phi2;
  logic [31:0] extaddr;
  logic [4:0]  extsz;
  logic        extreq, extwr, extsrc;
  logic [63:0] extwdata;
  logic        extrdy, extreply, extreplyto, exterror;
  logic [63:0] extrdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack, mem_err, werr;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int phi2_mode = 1;   // 0 low, 1 high, 2 alternating
  int mem_lat = 0;
  bit mem_hold = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } beat_t;
  typedef struct {
    logic        to;
    logic [63:0] data;
    logic        err;
  } rep_t;

  beat_t exp_mem[$];
  rep_t  exp_rep[$];

  cpu_busif #(.WBUF_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .phi2(phi2),
    .extaddr(extaddr), .extsz(extsz), .extreq(extreq), .extwr(extwr),
    .extsrc(extsrc), .extwdata(extwdata), .extrdy(extrdy),
    .extreply(extreply), .extreplyto(extreplyto), .extrdata(extrdata),
    .exterror(exterror), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err), .werr(werr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin : phi2_gen
    phi2 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (phi2_mode == 0)      phi2 = 0;
      else if (phi2_mode == 1) phi2 = 1;
      else                     phi2 = ~phi2;
    end
  end

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a, ~a};
  endfunction

  function automatic bit err_at(input logic [31:0] a);
    return (a == 32'h0000_6008) || (a == 32'h0000_7000);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    beat_t e;
    e.we = 1; e.addr = a; e.wdata = d; e.wstrb = s;
    exp_mem.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] a);
    beat_t e;
    e.we = 0; e.addr = a; e.wdata = '0; e.wstrb = '0;
    exp_mem.push_back(e);
  endtask

  task automatic push_rep(input logic to, input logic [31:0] a, input logic err);
    rep_t r;
    r.to = to; r.data = mem_word(a); r.err = err;
    exp_rep.push_back(r);
  endtask

  // Present one request and hold it until an accepting edge (bounded).
  task automatic send(input logic [31:0] a, input logic [4:0] sz, input logic wr,
                      input logic src, input logic [63:0] d);
    bit ok = 0;
    bit done = 0;
    int n = 0;
    @(negedge clk);
    extaddr = a; extsz = sz; extwr = wr; extsrc = src; extwdata = d; extreq = 1;
    while (!done && n < 200) begin
      #1;
      ok = phi2 && extrdy;
      @(posedge clk);
      if (ok) begin
        #1;
        extreq = 0;
        done = 1;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    if (!done) begin
      extreq = 0;
      check("accept_timeout", done, 1);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_rep.size() != 0 || mem_req || extreply) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {exp_mem.size() != 0, exp_rep.size() != 0}, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {extrdy, extreply, extreplyto, exterror, mem_req, mem_we, werr,
                          mem_wstrb, mem_addr}, 0);
    check({tag, "_data"}, {extrdata, mem_wdata}, 0);
  endtask

  // Memory responder: acks after mem_lat cycles and checks each beat in order.
  initial begin : memory_model
    int wait_cnt;
    bit last_we, last_err;
    beat_t e;
    mem_ack = 0; mem_rdata = '0; mem_err = 0;
    wait_cnt = 0; last_we = 0; last_err = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mem_ack = 0; mem_err = 0; wait_cnt = 0;
      end else if (mem_ack) begin
        if (last_we) check("werr", werr, last_err);
        mem_ack = 0; mem_err = 0; mem_rdata = '0; wait_cnt = 0;
      end else if (mem_req && !mem_hold) begin
        if (wait_cnt < mem_lat) begin
          wait_cnt++;
        end else begin
          check("mem_beat_expected", exp_mem.size() > 0, 1);
          if (exp_mem.size() > 0) begin
            e = exp_mem.pop_front();
            check("mem_we", mem_we, e.we);
            check("mem_addr", mem_addr, e.addr);
            if (e.we) begin
              check("mem_wdata", mem_wdata, e.wdata);
              check("mem_wstrb", mem_wstrb, e.wstrb);
            end
          end
          mem_ack   = 1;
          mem_err   = err_at(mem_addr);
          mem_rdata = mem_we ? 64'd0 : mem_word(mem_addr);
          last_we   = mem_we;
          last_err  = err_at(mem_addr);
        end
      end
    end
  end

  // Reply monitor: a beat is taken on an edge where phi2 is high.
  initial begin : reply_monitor
    bit prev_rep, prev_phi2;
    logic [63:0] prev_data;
    rep_t r;
    prev_rep = 0; prev_phi2 = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_rep = 0;
      end else begin
        if (prev_rep && !prev_phi2) begin
          check("reply_held", extreply, 1);
          check("reply_held_data", extrdata, prev_data);
        end
        if (extreply && phi2) begin
          check("reply_expected", exp_rep.size() > 0, 1);
          if (exp_rep.size() > 0) begin
            r = exp_rep.pop_front();
            check("reply_to", extreplyto, r.to);
            check("reply_data", extrdata, r.data);
            check("reply_err", exterror, r.err);
          end
        end
        prev_rep = extreply; prev_phi2 = phi2; prev_data = extrdata;
      end
    end
  end

  initial begin : stimulus
    int n;
    rstn = 0; extaddr = '0; extsz = '0; extreq = 0; extwr = 0; extsrc = 0; extwdata = '0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_outs");
    @(negedge clk);
    rstn = 1;
    #1 check("rdy_after_reset", extrdy, 1);

    // uncached dcache halfword write
    phi2_mode = 1; mem_lat = 0;
    push_w(32'h0000_1000, 64'h0000_BEEF_0000_0000, 8'h30);
    send(32'h0000_1002, 5'd1, 1, 1, 64'h0000_0000_0000_BEEF);
    wait_drain("t1_drain");

    // dcache 16-byte line read, critical word first, phi2 alternating
    phi2_mode = 2; mem_lat = 1;
    push_r(32'h0000_2008); push_r(32'h0000_2000);
    push_rep(1, 32'h0000_2008, 0); push_rep(1, 32'h0000_2000, 0);
    send(32'h0000_2008, 5'd15, 0, 1, 64'd0);
    wait_drain("t2_drain");

    // icache 32-byte line read with wrap
    mem_lat = 2;
    push_r(32'h0000_3010); push_r(32'h0000_3018); push_r(32'h0000_3000); push_r(32'h0000_3008);
    push_rep(0, 32'h0000_3010, 0); push_rep(0, 32'h0000_3018, 0);
    push_rep(0, 32'h0000_3000, 0); push_rep(0, 32'h0000_3008, 0);
    send(32'h0000_3010, 5'd31, 0, 0, 64'd0);
    wait_drain("t3_drain");

    // line read followed by dirty writeback: writes reach memory first
    phi2_mode = 1; mem_lat = 0;
    push_w(32'h0000_5000, 64'h1111_2222_3333_4444, 8'hFF);
    push_w(32'h0000_5008, 64'h5555_6666_7777_8888, 8'hFF);
    push_r(32'h0000_4000); push_r(32'h0000_4008);
    push_rep(1, 32'h0000_4000, 0); push_rep(1, 32'h0000_4008, 0);
    send(32'h0000_4000, 5'd15, 0, 1, 64'd0);
    send(32'h0000_5000, 5'd15, 1, 1, 64'h1111_2222_3333_4444);
    send(32'hDEAD_0000, 5'd15, 1, 1, 64'h5555_6666_7777_8888);
    wait_drain("t4_drain");

    // fill the FIFO with memory stalled, then a read with an errored beat
    mem_hold = 1;
    push_w(32'h0000_7000, 64'h0102_0304_0506_0708, 8'hFF);
    push_w(32'h0000_7008, 64'h0000_0000_1122_3344, 8'h0F);
    push_w(32'h0000_7010, 64'h0000_0000_0000_00AA, 8'h01);
    push_w(32'h0000_7018, 64'h5A00_0000_0000_0000, 8'h80);
    send(32'h0000_7000, 5'd7, 1, 1, 64'h0102_0304_0506_0708);
    send(32'h0000_700C, 5'd3, 1, 1, 64'h0000_0000_1122_3344);
    send(32'h0000_7017, 5'd0, 1, 1, 64'h0000_0000_0000_00AA);
    send(32'h0000_7018, 5'd0, 1, 1, 64'h0000_0000_0000_005A);
    @(negedge clk);
    extwr = 1;
    #1 check("full_rdy_write", extrdy, 0);
    extwr = 0;
    #1 check("full_rdy_read", extrdy, 1);
    push_r(32'h0000_6000); push_r(32'h0000_6008);
    push_rep(1, 32'h0000_6000, 0); push_rep(1, 32'h0000_6008, 1);
    send(32'h0000_6000, 5'd15, 0, 1, 64'd0);
    mem_hold = 0;
    wait_drain("t5_drain");

    // reset while the first of two reply beats is waiting for phi2
    phi2_mode = 1; mem_lat = 0;
    push_r(32'h0000_8000);
    send(32'h0000_8000, 5'd15, 0, 1, 64'd0);
    phi2_mode = 0;
    n = 0;
    while (!extreply && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reply_seen", extreply, 1);
    #2 rstn = 0;
    #1 check_all_zero("midreset_outs");
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    phi2_mode = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {mem_req, extreply}, 0);
    end
    extwr = 1;
    #1 check("post_reset_rdy_w", extrdy, 1);
    extwr = 0;
    #1 check("post_reset_rdy_r", extrdy, 1);
    push_w(32'h0000_1008, 64'hCAFE_F00D_1234_5678, 8'hFF);
    send(32'h0000_1008, 5'd7, 1, 0, 64'hCAFE_F00D_1234_5678);
    wait_drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
